// File: rtl/if_fetch_stage.sv
// ----------------------------------------------------------------------------
// if_fetch_stage
//   Instruction-fetch stage in front of the IF/ID pipeline register. Owns the
//   PC, issues req/ack fetches to instruction memory, parks a fetched word
//   while IF/ID is stalled, and discards the in-flight fetch when the stream
//   is redirected before its ack arrives.
//
// Parameters
//   RESET_PC        PC loaded on reset (word aligned)
// Ports
//   clock           clock, all state updates on posedge
//   reset           synchronous, active-high reset
//   stall           IF/ID must not accept a new instruction this cycle
//   redirect_valid  fetch stream redirected to redirect_pc
//   redirect_pc     new fetch address, bits [1:0] forced to zero
//   imem_req        fetch request, held with imem_addr stable until imem_ack
//   imem_addr       word-aligned fetch address
//   imem_ack        one-cycle pulse, imem_rdata valid
//   imem_rdata      fetched instruction word
//   instruction_o   instruction presented to IF/ID
//   pc_o            address of instruction_o
//   pc_inc_o        pc_o + 4 (modulo 2^64)
//   pc_branch_o     pc_o + sign-extended (instruction_o[25:0] << 2)
//   if_id_write     IF/ID write enable
//   if_id_flush     IF/ID flush (combinational copy of redirect_valid)
// ----------------------------------------------------------------------------
module if_fetch_stage #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction_o,
  output logic [63:0] pc_o,
  output logic [63:0] pc_inc_o,
  output logic [63:0] pc_branch_o,
  output logic        if_id_write,
  output logic        if_id_flush
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DROP  = 2'd3
  } state_t;

  state_t      state;
  logic [63:0] pc;
  logic [31:0] hold_instr;
  logic [63:0] redir_q;

  logic [63:0] redirect_aligned;
  logic        fetch_valid;

  assign redirect_aligned = {redirect_pc[63:2], 2'b00};

  // Fetch sequencer: PC, state, parked instruction and pending redirect target.
  // Redirect is examined before stall in every state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      hold_instr <= 32'h0;
      redir_q    <= 64'h0;
    end else begin
      case (state)
        IDLE: begin
          state <= FETCH;
        end
        FETCH: begin
          if (redirect_valid) begin
            if (imem_ack) begin
              // Word arrived in the redirect cycle: drop it, refetch at once.
              pc <= redirect_aligned;
            end else begin
              // Request still outstanding: address must stay stable until the ack.
              redir_q <= redirect_aligned;
              state   <= DROP;
            end
          end else if (imem_ack) begin
            if (stall) begin
              hold_instr <= imem_rdata;
              state      <= HOLD;
            end else begin
              pc <= pc + 64'd4;
            end
          end else begin
            state <= FETCH;
          end
        end
        HOLD: begin
          if (redirect_valid) begin
            pc    <= redirect_aligned;
            state <= FETCH;
          end else if (!stall) begin
            pc    <= pc + 64'd4;
            state <= FETCH;
          end else begin
            state <= HOLD;
          end
        end
        DROP: begin
          if (imem_ack) begin
            // A redirect coinciding with the ack is newer than redir_q.
            pc    <= redirect_valid ? redirect_aligned : redir_q;
            state <= FETCH;
          end else if (redirect_valid) begin
            redir_q <= redirect_aligned;
          end else begin
            state <= DROP;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Output decode: memory request, IF/ID payload and IF/ID control.
  always_comb begin
    imem_req      = 1'b0;
    instruction_o = 32'h0;
    fetch_valid   = 1'b0;
    case (state)
      FETCH: begin
        imem_req      = 1'b1;
        instruction_o = imem_rdata;
        fetch_valid   = imem_ack & ~redirect_valid;
      end
      HOLD: begin
        imem_req      = 1'b0;
        instruction_o = hold_instr;
        fetch_valid   = ~redirect_valid;
      end
      DROP: begin
        imem_req      = 1'b1;
        instruction_o = 32'h0;
        fetch_valid   = 1'b0;
      end
      default: begin
        imem_req      = 1'b0;
        instruction_o = 32'h0;
        fetch_valid   = 1'b0;
      end
    endcase
  end

  assign imem_addr   = pc;
  assign pc_o        = pc;
  assign pc_inc_o    = pc + 64'd4;
  assign pc_branch_o = pc + {{36{instruction_o[25]}}, instruction_o[25:0], 2'b00};
  assign if_id_write = fetch_valid & ~stall;
  assign if_id_flush = redirect_valid;

endmodule

// File: tb/tb_if_fetch_stage.sv
module tb_if_fetch_stage;

  localparam logic [63:0] RPC = 64'h1000;

  logic        clock;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instruction_o;
  logic [63:0] pc_o;
  logic [63:0] pc_inc_o;
  logic [63:0] pc_branch_o;
  logic        if_id_write;
  logic        if_id_flush;

  int vectors;
  int miscompares;

  // Reference model state, expressed as data availability rather than FSM states:
  // running (past the post-reset idle cycle), architectural PC, a parked word,
  // and a redirect target waiting for the outstanding fetch to complete.
  logic        m_run;
  logic [63:0] m_pc;
  logic        m_held;
  logic [31:0] m_hword;
  logic        m_pend;
  logic [63:0] m_tgt;
  logic        sb_on;

  if_fetch_stage #(.RESET_PC(RPC)) dut (
    .clock(clock), .reset(reset), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .instruction_o(instruction_o), .pc_o(pc_o),
    .pc_inc_o(pc_inc_o), .pc_branch_o(pc_branch_o),
    .if_id_write(if_id_write), .if_id_flush(if_id_flush)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] memword(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, check outputs 1ns
  // later against the model, then advance the model past the next rising edge.
  task automatic drive(input logic rs, input logic st, input logic rv,
                       input logic [63:0] rpc, input logic a,
                       input logic use_d, input logic [31:0] d);
    logic        e_req;
    logic        avail;
    logic        e_fv;
    logic [31:0] e_instr;
    logic signed [27:0] off28;
    longint      off;
    @(negedge clock);
    e_req          = m_run && !m_held && 1'b1;
    reset          = rs;
    stall          = st;
    redirect_valid = rv;
    redirect_pc    = rpc;
    imem_ack       = a && e_req;
    imem_rdata     = use_d ? d : (imem_ack ? memword(m_pc) : $urandom);
    #1;
    avail   = m_run && (m_held || imem_ack);
    e_fv    = avail && !rv && !m_pend;
    e_instr = m_held ? m_hword : ((m_run && !m_pend) ? imem_rdata : 32'h0);
    off28   = {e_instr[25:0], 2'b00};
    off     = off28;
    chk("req",       {63'h0, imem_req},    {63'h0, e_req});
    chk("addr",      imem_addr,            m_pc);
    chk("pc_o",      pc_o,                 m_pc);
    chk("pc_inc",    pc_inc_o,             m_pc + 64'd4);
    chk("instr",     {32'h0, instruction_o}, {32'h0, e_instr});
    chk("pc_branch", pc_branch_o,          m_pc + off);
    chk("write",     {63'h0, if_id_write}, {63'h0, e_fv && !st});
    chk("flush",     {63'h0, if_id_flush}, {63'h0, rv});
    if (sb_on && e_fv && !st)
      chk("sb_word", {32'h0, instruction_o}, {32'h0, memword(m_pc)});
    if (rs) begin
      m_run = 1'b0; m_pc = RPC; m_held = 1'b0; m_pend = 1'b0;
    end else if (!m_run) begin
      m_run = 1'b1;
    end else if (rv) begin
      if (e_req && !imem_ack) begin
        m_pend = 1'b1;
        m_tgt  = rpc & ~64'd3;
      end else begin
        m_pc = rpc & ~64'd3; m_held = 1'b0; m_pend = 1'b0;
      end
    end else if (m_pend) begin
      if (imem_ack) begin
        m_pc = m_tgt; m_pend = 1'b0;
      end
    end else if (avail) begin
      if (!st) begin
        m_pc = m_pc + 64'd4; m_held = 1'b0;
      end else if (!m_held) begin
        m_held = 1'b1; m_hword = imem_rdata;
      end
    end
  endtask

  task automatic cyc(input logic st, input logic rv, input logic [63:0] rpc, input logic a);
    drive(1'b0, st, rv, rpc, a, 1'b0, 32'h0);
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    vectors = 0; miscompares = 0; sb_on = 1'b0;
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 64'h0;
    imem_ack = 1'b0; imem_rdata = 32'h0;
    m_run = 1'b0; m_pc = RPC; m_held = 1'b0; m_hword = 32'h0; m_pend = 1'b0; m_tgt = 64'h0;
    repeat (2) @(posedge clock);

    // 1: reset state, then zero-wait memory streams one word per cycle
    cyc(1'b0, 1'b0, 64'h0, 1'b1);
    chk("t1_idle_req", {63'h0, imem_req}, 64'h0);
    chk("t1_idle_wr",  {63'h0, if_id_write}, 64'h0);
    cyc(1'b0, 1'b0, 64'h0, 1'b1);
    chk("t1_addr0", imem_addr, 64'h1000);
    chk("t1_wr0",   {63'h0, if_id_write}, 64'h1);
    cyc(1'b0, 1'b0, 64'h0, 1'b1);
    chk("t1_addr1", imem_addr, 64'h1004);
    cyc(1'b0, 1'b0, 64'h0, 1'b1);
    chk("t1_addr2", imem_addr, 64'h1008);
    chk("t1_wr2",   {63'h0, if_id_write}, 64'h1);

    // 2: ack three cycles after the request
    do_reset();
    cyc(1'b0, 1'b0, 64'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 64'h0, 1'b0);
      chk("t2_wait_addr", imem_addr, 64'h1000);
      chk("t2_wait_req",  {63'h0, imem_req}, 64'h1);
      chk("t2_wait_wr",   {63'h0, if_id_write}, 64'h0);
    end
    cyc(1'b0, 1'b0, 64'h0, 1'b1);
    chk("t2_wr",     {63'h0, if_id_write}, 64'h1);
    chk("t2_pc",     pc_o, 64'h1000);
    chk("t2_pc_inc", pc_inc_o, 64'h1004);

    // 3: ack while stalled parks the word until stall drops
    cyc(1'b1, 1'b0, 64'h0, 1'b1);
    chk("t3_stall_wr", {63'h0, if_id_write}, 64'h0);
    cyc(1'b1, 1'b0, 64'h0, 1'b0);
    chk("t3_hold_req", {63'h0, imem_req}, 64'h0);
    chk("t3_hold_wr",  {63'h0, if_id_write}, 64'h0);
    cyc(1'b0, 1'b0, 64'h0, 1'b0);
    chk("t3_rel_wr",    {63'h0, if_id_write}, 64'h1);
    chk("t3_rel_pc",    pc_o, 64'h1004);
    chk("t3_rel_instr", {32'h0, instruction_o}, {32'h0, memword(64'h1004)});
    cyc(1'b0, 1'b0, 64'h0, 1'b0);
    chk("t3_next_addr", imem_addr, 64'h1008);

    // 4: redirect while a fetch is outstanding; its data must be dropped
    cyc(1'b0, 1'b1, 64'h2002, 1'b0);
    chk("t4_flush", {63'h0, if_id_flush}, 64'h1);
    cyc(1'b0, 1'b0, 64'h0, 1'b0);
    chk("t4_drop_flush", {63'h0, if_id_flush}, 64'h0);
    chk("t4_drop_addr",  imem_addr, 64'h1008);
    cyc(1'b0, 1'b0, 64'h0, 1'b1);
    chk("t4_drop_wr", {63'h0, if_id_write}, 64'h0);
    cyc(1'b0, 1'b0, 64'h0, 1'b0);
    chk("t4_new_addr", imem_addr, 64'h2000);

    // 5: early branch target from instruction bits [25:0]
    do_reset();
    cyc(1'b0, 1'b0, 64'h0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b1, 32'h17FF_FFFF);
    chk("t5_br_neg", pc_branch_o, 64'h0FFC);
    drive(1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b1, 32'h1400_0010);
    chk("t5_br_pos", pc_branch_o, 64'h1040);

    // 6: PC wrap-around, then reset while in the drop phase
    cyc(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1);
    cyc(1'b0, 1'b0, 64'h0, 1'b1);
    chk("t6_pc",     pc_o, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("t6_pc_inc", pc_inc_o, 64'h0);
    chk("t6_wr",     {63'h0, if_id_write}, 64'h1);
    cyc(1'b0, 1'b0, 64'h0, 1'b0);
    chk("t6_wrap_addr", imem_addr, 64'h0);
    cyc(1'b0, 1'b1, 64'h3000, 1'b0);
    do_reset();
    chk("t6_drop_req", {63'h0, imem_req}, 64'h1);
    cyc(1'b0, 1'b0, 64'h0, 1'b0);
    chk("t6_rst_req", {63'h0, imem_req}, 64'h0);
    cyc(1'b0, 1'b0, 64'h0, 1'b0);
    chk("t6_rst_addr", imem_addr, RPC);
    chk("t6_rst_req2", {63'h0, imem_req}, 64'h1);

    // Randomized traffic with the word scoreboard enabled
    sb_on = 1'b1;
    for (int n = 0; n < 2000; n++) begin
      logic        r_rs;
      logic        r_st;
      logic        r_rv;
      logic        r_a;
      logic [63:0] r_pc;
      r_rs = ($urandom_range(0, 99) == 0);
      r_st = ($urandom_range(0, 2) == 0);
      r_rv = ($urandom_range(0, 7) == 0);
      r_a  = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 3) == 0)
        r_pc = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15));
      else
        r_pc = {$urandom, $urandom};
      drive(r_rs, r_st, r_rv, r_pc, r_a, 1'b0, 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
